// File: rtl/data_memory_lsu.sv
// data_memory_lsu
//   Byte-addressed data memory with sub-word load/store, sign/zero extension
//   and misalignment detection. Sits between the CPU load/store stage and the
//   data RAM. One request is accepted at a time. The response comes LATENCY
//   cycles after acceptance and cannot be stalled.
//
// Parameters
//   DATA_WIDTH : word width, 32 or 64
//   ADDR_WIDTH : byte-address width
//   LATENCY    : cycles from acceptance to rsp_valid (>= 1)
//   INIT_FILE  : preload name; the array is zero-filled
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   req_valid    in   request present
//   req_ready    out  request can be accepted (IDLE only)
//   req_we       in   1 = store, 0 = load
//   req_size     in   0 byte, 1 half, 2 word, 3 double
//   req_unsigned in   loads: 1 zero-extend, 0 sign-extend
//   req_addr     in   byte address
//   req_wdata    in   store data, right-aligned
//   rsp_valid    out  one-cycle response strobe
//   rsp_rdata    out  extended load data; 0 for stores and errors
//   rsp_err      out  misaligned or illegal-size access
module data_memory_lsu #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 1,
   parameter     INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LW    = $clog2(BYTES);
   localparam int DEPTH = 1 << (ADDR_WIDTH - LW);
   localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                  r_state;
   logic                    r_req_ready;
   logic                    r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;
   logic                    r_rsp_err;
   logic [CW-1:0]           r_cnt;
   logic [DATA_WIDTH-1:0]   r_load;
   logic                    r_err_p;

   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

   logic                    w_acc;
   logic                    w_wr;
   logic                    w_err;
   logic [LW-1:0]           w_lane;
   logic [2:0]              w_lane3;
   logic [ADDR_WIDTH-LW-1:0] w_idx;
   logic [7:0]              w_szm;
   logic [BYTES-1:0]        w_be;
   logic [DATA_WIDTH-1:0]   w_wdata_sh;
   logic [DATA_WIDTH-1:0]   w_rword;
   logic [DATA_WIDTH-1:0]   w_rsh;
   logic [DATA_WIDTH-1:0]   w_mask;
   logic                    w_sign;
   logic [DATA_WIDTH-1:0]   w_ld;
   logic [DATA_WIDTH-1:0]   w_ld_res;

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

   // req_ready is only ever high in IDLE, so this is the acceptance strobe
   assign w_acc   = req_valid & r_req_ready;
   assign w_lane  = req_addr[LW-1:0];
   assign w_lane3 = 3'(w_lane);
   assign w_idx   = req_addr[ADDR_WIDTH-1:LW];

   // Lane must be a multiple of the access size; doubles need a 64-bit word
   always_comb begin
      w_err = 1'b0;
      case (req_size)
         2'd0:    w_err = 1'b0;
         2'd1:    w_err = w_lane3[0];
         2'd2:    w_err = |w_lane3[1:0];
         default: w_err = (BYTES != 8) || (|w_lane3);
      endcase
   end

   always_comb begin
      w_szm = 8'h01;
      case (req_size)
         2'd0:    w_szm = 8'h01;
         2'd1:    w_szm = 8'h03;
         2'd2:    w_szm = 8'h0F;
         default: w_szm = 8'hFF;
      endcase
   end

   // Legal accesses never shift enable bits past the top lane
   assign w_be       = BYTES'(w_szm) << w_lane;
   assign w_wdata_sh = req_wdata << {w_lane, 3'b000};
   assign w_wr       = w_acc & req_we & ~w_err;

   // Load path: align the addressed bytes down to bit 0, then mask/extend.
   // A full-width access has an all-ones mask, so ~mask is zero and the
   // extension choice has no effect.
   assign w_rword = r_mem[w_idx];
   assign w_rsh   = w_rword >> {w_lane, 3'b000};

   always_comb begin
      w_mask = '1;
      w_sign = w_rsh[DATA_WIDTH-1];
      case (req_size)
         2'd0:    begin w_mask = DATA_WIDTH'(8'hFF);         w_sign = w_rsh[7];  end
         2'd1:    begin w_mask = DATA_WIDTH'(16'hFFFF);      w_sign = w_rsh[15]; end
         2'd2:    begin w_mask = DATA_WIDTH'(32'hFFFF_FFFF); w_sign = w_rsh[31]; end
         default: begin w_mask = '1;                         w_sign = w_rsh[DATA_WIDTH-1]; end
      endcase
   end

   assign w_ld     = (w_rsh & w_mask) | ((w_sign & ~req_unsigned) ? ~w_mask : '0);
   assign w_ld_res = (req_we | w_err) ? '0 : w_ld;

   // Zero-fill; the array is not touched by reset
   initial begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
   end

   // Store commits at the acceptance edge so a following load sees it
   always_ff @(posedge clk) begin
      if (w_wr) begin
         for (int b = 0; b < BYTES; b++) begin
            if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_cnt       <= '0;
         r_load      <= '0;
         r_err_p     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_acc) begin
                  r_load      <= w_ld_res;
                  r_err_p     <= w_err;
                  r_req_ready <= 1'b0;
                  if (LATENCY == 1) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_rdata <= w_ld_res;
                     r_rsp_err   <= w_err;
                  end else begin
                     r_state <= S_WAIT;
                     r_cnt   <= CW'(1);
                  end
               end
            end
            S_WAIT: begin
               // Counter started at 1 on acceptance, so RESP begins
               // LATENCY edges after the acceptance edge
               if (r_cnt == CNT_LAST) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= r_load;
                  r_rsp_err   <= r_err_p;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_RESP: begin
               r_state     <= S_IDLE;
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
               r_cnt       <= '0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
               r_cnt       <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_lsu.sv
module tb_data_memory_lsu;

   localparam int DW  = 64;
   localparam int AW  = 12;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [1:0]    req_size = 2'd0;
   logic          req_unsigned = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;

   data_memory_lsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(LAT), .INIT_FILE("")) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic          e;
      int            cyc;
      string         nm;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every rsp_valid pulse must match the oldest expectation
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected no response", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check({e.nm, "_rdata"}, rsp_rdata, e.d);
            check({e.nm, "_err"}, DW'(rsp_err), DW'(e.e));
            check({e.nm, "_latency"}, DW'(cyc), DW'(e.cyc));
         end
      end
   end

   // Drive one request, wait for acceptance, push the expectation
   task automatic issue(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] ed, input logic ee, input bit push);
      bit ok = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      for (int k = 0; k < 20 && !ok; k++) begin
         if (req_ready === 1'b1) begin
            ok = 1;
            if (push) q.push_back('{ed, ee, cyc + LAT, nm});
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      if (!ok) begin
         n_tests++; n_fail++;
         $display("FAIL %s_accept: got no acceptance in 20 cycles expected acceptance", nm);
      end else begin
         check({nm, "_ready_low"}, DW'(req_ready), DW'(0));
      end
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (q.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      logic [7:0]  pat;
      logic [7:0]  bytes [8];
      bytes = '{8'h10, 8'h55, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready", DW'(req_ready), DW'(1));
      check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
      check("rst_rsp_rdata", rsp_rdata, '0);
      check("rst_rsp_err",   DW'(rsp_err), DW'(0));
      rst = 1'b1;

      // 1: full-width store / load
      issue("sd_1a8", 1, 2'd3, 0, 12'h1A8, 64'hFEDCBA9876543210, 64'h0, 0, 1);
      issue("ld_1a8", 0, 2'd3, 0, 12'h1A8, 64'h0, 64'hFEDCBA9876543210, 0, 1);
      drain();

      // 2: byte store into lane 1
      issue("sb_1a9", 1, 2'd0, 0, 12'h1A9, 64'h55, 64'h0, 0, 1);
      issue("ld_after_sb", 0, 2'd3, 0, 12'h1A8, 64'h0, 64'hFEDCBA9876545510, 0, 1);
      drain();

      // 3: sub-word loads with extension
      issue("lb_1af",  0, 2'd0, 0, 12'h1AF, 64'h0, 64'hFFFFFFFFFFFFFFFE, 0, 1);
      issue("lbu_1af", 0, 2'd0, 1, 12'h1AF, 64'h0, 64'h00000000000000FE, 0, 1);
      issue("lh_1ae",  0, 2'd1, 0, 12'h1AE, 64'h0, 64'hFFFFFFFFFFFFFEDC, 0, 1);
      issue("lwu_1ac", 0, 2'd2, 1, 12'h1AC, 64'h0, 64'h00000000FEDCBA98, 0, 1);
      issue("lw_1ac",  0, 2'd2, 0, 12'h1AC, 64'h0, 64'hFFFFFFFFFEDCBA98, 0, 1);
      issue("lw_1a8",  0, 2'd2, 0, 12'h1A8, 64'h0, 64'h0000000076545510, 0, 1);
      drain();

      // 4: misaligned accesses
      issue("sw_1aa_mis", 1, 2'd2, 0, 12'h1AA, 64'h12345678, 64'h0, 1, 1);
      issue("ld_after_mis", 0, 2'd3, 0, 12'h1A8, 64'h0, 64'hFEDCBA9876545510, 0, 1);
      issue("lh_1a9_mis", 0, 2'd1, 0, 12'h1A9, 64'h0, 64'h0, 1, 1);
      issue("ld_1ac_mis", 0, 2'd3, 0, 12'h1AC, 64'h0, 64'h0, 1, 1);
      // Half store uses only the low bytes of wdata
      issue("sh_1b2", 1, 2'd1, 0, 12'h1B2, 64'h1111222233334EEF, 64'h0, 0, 1);
      issue("lhu_1b2", 0, 2'd1, 1, 12'h1B2, 64'h0, 64'h0000000000004EEF, 0, 1);
      issue("ld_1b0", 0, 2'd3, 0, 12'h1B0, 64'h0, 64'h000000004EEF0000, 0, 1);
      drain();

      // 5: req_valid held high, address changing every cycle
      pat = 8'b0100_1001;
      for (int i = 0; i < 8; i++) begin
         req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b1;
         req_addr = AW'(12'h1A8 + i);
         check($sformatf("stream_ready_%0d", i), DW'(req_ready), DW'(pat[i]));
         if (req_ready === 1'b1)
            q.push_back('{DW'(bytes[i]), 1'b0, cyc + LAT, $sformatf("stream_lbu_%0d", i)});
         @(negedge clk);
      end
      req_valid = 1'b0;
      drain();

      // 6: reset with a response pending
      issue("ld_dropped", 0, 2'd3, 0, 12'h1A8, 64'h0, 64'h0, 0, 0);
      rst = 1'b0;
      #1;
      check("midrst_ready", DW'(req_ready), DW'(1));
      check("midrst_rsp_valid", DW'(rsp_valid), DW'(0));
      repeat (3) @(negedge clk);
      rst = 1'b1;
      issue("ld_after_rst", 0, 2'd3, 0, 12'h1A8, 64'h0, 64'hFEDCBA9876545510, 0, 1);
      drain();
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
